// File: rtl/regfile_arbiter_pkg.sv
// Purpose : shared definitions for the register-file arbiter slice.
//   - default sizing constants NUM_REQ, ADDR_W, DATA_W
//   - FSM state encoding (IDLE -> ISSUE -> [CAPTURE] -> IDLE)
// Optional feature macro used by the slice: REGFILE_ARB_RR_EN (round-robin).
package regfile_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Purpose : requester-side bus of the register-file arbiter.
// Signals : req/we (one bit per requester), addr/wdata (packed per requester),
//           gnt/rvalid (one-hot pulses back to requesters), rdata (shared).
// Modports: master = requester side, slave = arbiter side.
interface regfile_arbiter_if #(
  parameter int NUM_REQ = regfile_arb_pkg::NUM_REQ,
  parameter int ADDR_W  = regfile_arb_pkg::ADDR_W,
  parameter int DATA_W  = regfile_arb_pkg::DATA_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/regfile_arbiter_rr_picker.sv
// Purpose : combinational one-hot pick among requesters, searching upward
//           from ptr_i and wrapping at NUM_REQ. With ptr_i tied to 0 this is
//           fixed priority, requester 0 highest.
// Ports   : req_i      request vector
//           ptr_i      index of the highest-priority requester
//           pick_oh_o  one-hot winner (all zero when no request)
//           pick_idx_o winner index (0 when no request)
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_oh_o,
  output logic [IDX_W-1:0]   pick_idx_o
);
  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam int CW = IDX_W + 1;

  logic [CW-1:0] sum_s;
  logic [CW-1:0] cand_s;
  logic          found_s;

  // Rotating priority search: first requesting index at or above the pointer.
  always_comb begin
    pick_oh_o  = '0;
    pick_idx_o = '0;
    found_s    = 1'b0;
    sum_s      = '0;
    cand_s     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s  = {1'b0, ptr_i} + CW'(i);
      cand_s = (sum_s >= CW'(NUM_REQ)) ? (sum_s - CW'(NUM_REQ)) : sum_s;
      if (!found_s && req_i[cand_s[IDX_W-1:0]]) begin
        found_s                        = 1'b1;
        pick_idx_o                     = cand_s[IDX_W-1:0];
        pick_oh_o[cand_s[IDX_W-1:0]]   = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
endmodule

// File: rtl/regfile_arbiter.sv
// Purpose : arbitrates NUM_REQ requesters onto one single-port-style register
//           file. One access at a time: IDLE (arbitrate + latch) -> ISSUE
//           (gnt + rf strobe) -> CAPTURE (reads only: rvalid + rdata) -> IDLE.
//           All outputs are registered.
// Ports   : clock, reset (async, active-low)
//           bus          requester interface (slave modport)
//           busy         high while the FSM is not in IDLE
//           rf_load      register-file write strobe, with rf_load_addr/rf_data_in
//           rf_store     register-file read strobe, with rf_store_addr
//           rf_data_out  register-file read data, sampled in CAPTURE
// Config  : define REGFILE_ARB_RR_EN for round-robin arbitration; otherwise
//           fixed priority with requester 0 highest.
module regfile_arbiter #(
  parameter int NUM_REQ = regfile_arb_pkg::NUM_REQ,
  parameter int ADDR_W  = regfile_arb_pkg::ADDR_W,
  parameter int DATA_W  = regfile_arb_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  regfile_arbiter_if.slave  bus,
  output logic              busy,
  output logic              rf_load,
  output logic              rf_store,
  output logic [ADDR_W-1:0] rf_load_addr,
  output logic [ADDR_W-1:0] rf_store_addr,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out
);
  import regfile_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e              state_q;
  logic [IDX_W-1:0]    win_idx_q;
  logic                win_we_q;
  logic [ADDR_W-1:0]   win_addr_q;
  logic [DATA_W-1:0]   win_data_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic                rf_load_q;
  logic                rf_store_q;
  logic [ADDR_W-1:0]   rf_load_addr_q;
  logic [ADDR_W-1:0]   rf_store_addr_q;
  logic [DATA_W-1:0]   rf_data_in_q;

  logic [IDX_W-1:0]    ptr_s;
  logic [NUM_REQ-1:0]  pick_oh_s;
  logic [IDX_W-1:0]    pick_idx_s;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i      (bus.req),
    .ptr_i      (ptr_s),
    .pick_oh_o  (pick_oh_s),
    .pick_idx_o (pick_idx_s)
  );

`ifdef REGFILE_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // Priority moves to the requester after the one being granted, with wrap.
  always_comb begin
    ptr_d = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : (win_idx_q + IDX_W'(1));
  end

  // Pointer advances only when a grant is actually issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (state_q == ISSUE) begin
      ptr_q <= ptr_d;
    end else begin
      ptr_q <= ptr_q;
    end
  end

  assign ptr_s = ptr_q;
`else
  assign ptr_s = '0;
`endif

  // Access FSM; strobes default low every cycle so they are single-cycle
  // pulses, while rf addresses/data and rdata hold their last values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      win_idx_q       <= '0;
      win_we_q        <= 1'b0;
      win_addr_q      <= '0;
      win_data_q      <= '0;
      gnt_q           <= '0;
      rvalid_q        <= '0;
      rdata_q         <= '0;
      busy_q          <= 1'b0;
      rf_load_q       <= 1'b0;
      rf_store_q      <= 1'b0;
      rf_load_addr_q  <= '0;
      rf_store_addr_q <= '0;
      rf_data_in_q    <= '0;
    end else begin
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rf_load_q  <= 1'b0;
      rf_store_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|pick_oh_s) begin
            win_idx_q  <= pick_idx_s;
            win_we_q   <= bus.we[pick_idx_s];
            win_addr_q <= bus.addr[pick_idx_s*ADDR_W +: ADDR_W];
            win_data_q <= bus.wdata[pick_idx_s*DATA_W +: DATA_W];
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
          end
        end
        ISSUE: begin
          gnt_q[win_idx_q] <= 1'b1;
          if (win_we_q) begin
            rf_load_q      <= 1'b1;
            rf_load_addr_q <= win_addr_q;
            rf_data_in_q   <= win_data_q;
            state_q        <= IDLE;
            busy_q         <= 1'b0;
          end else begin
            rf_store_q      <= 1'b1;
            rf_store_addr_q <= win_addr_q;
            state_q         <= CAPTURE;
            busy_q          <= 1'b1;
          end
        end
        CAPTURE: begin
          // rf_data_out reflects the address driven with rf_store last cycle.
          rvalid_q[win_idx_q] <= 1'b1;
          rdata_q             <= rf_data_out;
          state_q             <= IDLE;
          busy_q              <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign busy          = busy_q;
  assign rf_load       = rf_load_q;
  assign rf_store      = rf_store_q;
  assign rf_load_addr  = rf_load_addr_q;
  assign rf_store_addr = rf_store_addr_q;
  assign rf_data_in    = rf_data_in_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: table of single accesses through a
// scoreboard, plus hand-written arbitration-order, wrap, abort-by-reset and
// back-to-back sequences. A behavioural register file sits on the rf_* side.
module tb_regfile_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  regfile_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          busy, rf_load, rf_store;
  logic [AW-1:0] rf_load_addr, rf_store_addr;
  logic [DW-1:0] rf_data_in, rf_data_out;

  regfile_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .busy          (busy),
    .rf_load       (rf_load),
    .rf_store      (rf_store),
    .rf_load_addr  (rf_load_addr),
    .rf_store_addr (rf_store_addr),
    .rf_data_in    (rf_data_in),
    .rf_data_out   (rf_data_out)
  );

  always #5 clock = ~clock;

  // Register-file model: write on rf_load, address held so read data is ready next edge.
  logic [DW-1:0] mem [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                               8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E, 8'h3F};
  always @(posedge clock) begin
    if (rf_load) mem[rf_load_addr] <= rf_data_in;
  end
  assign rf_data_out = mem[rf_store_addr];

  typedef struct {
    logic [1:0]    idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [N-1:0]  exp_gnt;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [DW-1:0] rdata;
  } exp_t;

  vec_t vecs [10];
  exp_t sb_q [$];
  int   arb_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return -1;
  endfunction

  // Per-cycle protocol invariants while out of reset.
  always @(negedge clock) begin
    if (reset) begin
      chk("strobe_excl", 32'(rf_load & rf_store), 32'd0);
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("rvalid_onehot0", 32'($onehot0(bus.rvalid)), 32'd1);
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rf_load"}, 32'(rf_load), 32'd0);
    chk({tag, "_rf_store"}, 32'(rf_store), 32'd0);
    chk({tag, "_rf_load_addr"}, 32'(rf_load_addr), 32'd0);
    chk({tag, "_rf_store_addr"}, 32'(rf_store_addr), 32'd0);
    chk({tag, "_rf_data_in"}, 32'(rf_data_in), 32'd0);
  endtask

  task automatic wait_gnt(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clock);
      lat++;
      got = (bus.gnt != '0);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.req = '0;
    reset   = 1'b0;
    #1;
    check_idle("rst");
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v);
    int   lat;
    bit   got;
    exp_t e;
    @(negedge clock);
    bus.req[v.idx]               = 1'b1;
    bus.we[v.idx]                = v.we;
    bus.addr[v.idx*AW +: AW]     = v.addr;
    bus.wdata[v.idx*DW +: DW]    = v.wdata;
    sb_q.push_back('{gnt: v.exp_gnt, rdata: v.exp_rdata});
    wait_gnt(lat, got);
    e = sb_q.pop_front();
    chk("gnt_seen", 32'(got), 32'd1);
    if (got) begin
      chk("gnt_latency", 32'(lat), 32'd2);
      chk("gnt_vec", 32'(bus.gnt), 32'(e.gnt));
      chk("rf_load", 32'(rf_load), 32'(v.we));
      chk("rf_store", 32'(rf_store), 32'(!v.we));
      if (v.we) begin
        chk("rf_load_addr", 32'(rf_load_addr), 32'(v.addr));
        chk("rf_data_in", 32'(rf_data_in), 32'(v.wdata));
      end else begin
        chk("rf_store_addr", 32'(rf_store_addr), 32'(v.addr));
      end
      bus.req[v.idx] = 1'b0;
      @(negedge clock);
      chk("rvalid", 32'(bus.rvalid), v.we ? 32'd0 : 32'(e.gnt));
      if (!v.we) chk("rdata", 32'(bus.rdata), 32'(e.rdata));
      chk("busy_after", 32'(busy), 32'd0);
    end
    bus.req[v.idx] = 1'b0;
  endtask

  // Writes from every requester in reqs; compares each grant against arb_q.
  task automatic arb_seq(input logic [N-1:0] reqs, input int n, input bit drop);
    int lat;
    bit got;
    int g;
    int e;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      if (reqs[i]) begin
        bus.req[i]             = 1'b1;
        bus.we[i]              = 1'b1;
        bus.addr[i*AW +: AW]   = AW'(8 + i);
        bus.wdata[i*DW +: DW]  = DW'(8'hC0 + i);
      end
    end
    for (int k = 0; k < n; k++) begin
      wait_gnt(lat, got);
      e = arb_q.pop_front();
      chk("arb_gnt_seen", 32'(got), 32'd1);
      if (got) begin
        g = oh2idx(bus.gnt);
        chk("arb_order", 32'(g), 32'(e));
        if (drop) bus.req[g] = 1'b0;
      end
    end
    bus.req = '0;
  endtask

  initial begin
    int   lat;
    bit   got;
    int   c0, c3, rv3;
    logic [DW-1:0] rd3;
    vec_t rv;

    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;

    vecs[0] = '{2'd2, 1'b1, 4'd5,  8'hA7, 4'b0100, 8'h00};
    vecs[1] = '{2'd1, 1'b0, 4'd5,  8'h00, 4'b0010, 8'hA7};
    vecs[2] = '{2'd0, 1'b1, 4'd0,  8'h00, 4'b0001, 8'h00};
    vecs[3] = '{2'd3, 1'b1, 4'd15, 8'hFF, 4'b1000, 8'h00};
    vecs[4] = '{2'd3, 1'b0, 4'd15, 8'h00, 4'b1000, 8'hFF};
    vecs[5] = '{2'd0, 1'b0, 4'd0,  8'h00, 4'b0001, 8'h00};
    vecs[6] = '{2'd2, 1'b0, 4'd9,  8'h00, 4'b0100, 8'h39};
    vecs[7] = '{2'd1, 1'b1, 4'd9,  8'h5A, 4'b0010, 8'h00};
    vecs[8] = '{2'd2, 1'b0, 4'd9,  8'h00, 4'b0100, 8'h5A};
    vecs[9] = '{2'd0, 1'b0, 4'd3,  8'h00, 4'b0001, 8'h33};

    // Reset state.
    @(negedge clock);
    check_idle("init");
    reset = 1'b1;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

    // All four requesting and held.
    do_reset();
`ifdef REGFILE_ARB_RR_EN
    arb_q = '{0, 1, 2, 3, 0};
`else
    arb_q = '{0, 0, 0, 0, 0};
`endif
    arb_seq(4'b1111, 5, 1'b0);

    // Wrap from the last requester back to 0.
    do_reset();
    arb_q = '{2};
    arb_seq(4'b0100, 1, 1'b1);
`ifdef REGFILE_ARB_RR_EN
    arb_q = '{3, 0};
`else
    arb_q = '{0, 3};
`endif
    arb_seq(4'b1001, 2, 1'b1);

    // Reset while the read is in CAPTURE aborts it.
    @(negedge clock);
    bus.req[1] = 1'b1; bus.we[1] = 1'b0; bus.addr[1*AW +: AW] = 4'd5;
    wait_gnt(lat, got);
    chk("abort_gnt_seen", 32'(got), 32'd1);
    bus.req[1] = 1'b0;
    reset = 1'b0;
    #1;
    check_idle("abort");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_no_rvalid", 32'(bus.rvalid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rv = '{2'd1, 1'b0, 4'd5, 8'h00, 4'b0010, 8'hA7};
    apply_vec(rv);

    // Write from 0 and read from 3 pending together.
    @(negedge clock);
    bus.req[0] = 1'b1; bus.we[0] = 1'b1; bus.addr[0 +: AW] = 4'd3;      bus.wdata[0 +: DW] = 8'h3C;
    bus.req[3] = 1'b1; bus.we[3] = 1'b0; bus.addr[3*AW +: AW] = 4'd15;
    c0 = 0; c3 = 0; rv3 = 0; rd3 = '0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (bus.gnt[0]) begin c0++; bus.req[0] = 1'b0; end
      if (bus.gnt[3]) begin c3++; bus.req[3] = 1'b0; end
      if (bus.rvalid[3]) begin rv3++; rd3 = bus.rdata; end
    end
    chk("b2b_gnt0_count", 32'(c0), 32'd1);
    chk("b2b_gnt3_count", 32'(c3), 32'd1);
    chk("b2b_rvalid3_count", 32'(rv3), 32'd1);
    chk("b2b_rdata", 32'(rd3), 32'hFF);
    chk("b2b_written", 32'(mem[3]), 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
